// File: rtl/banked_ram.sv
// Multi-lane beat-addressed RAM with per-lane write enables, one-cycle read latency,
// a single write-busy cycle after each in-range write, and an error pulse on out-of-range beats.
module banked_ram #(
    parameter int WORD_W = 10,
    parameter int LANES  = 2,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 21
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [LANES-1:0]        we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES*WORD_W-1:0] wdata,
    output logic [LANES*WORD_W-1:0] rdata,
    output logic                    rvalid,
    output logic                    err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE,
        WBUSY
    } state_t;

    state_t                    state;
    logic                      accept;
    logic                      in_range;
    logic                      is_write;
    logic [IDX_W-1:0]          beat;
    logic [LANES*WORD_W-1:0]   rd_word;

    // Ready drops combinationally with rst so no request is ever accepted during reset.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign in_range  = (32'(addr) < 32'(DEPTH));
    assign is_write  = |we;
    assign beat      = addr[IDX_W-1:0];

    // One storage array per lane; a beat never spans lanes of another beat.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [WORD_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (accept && in_range && we[g]) begin
                mem[beat] <= wdata[g*WORD_W +: WORD_W];
            end
        end

        assign rd_word[g*WORD_W +: WORD_W] = mem[beat];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= accept && in_range && !is_write;
            err    <= accept && !in_range;
            if (accept && !is_write) begin
                rdata <= in_range ? rd_word : '0;
            end
            case (state)
                IDLE: begin
                    if (accept && in_range && is_write) begin
                        state <= WBUSY;
                    end
                end
                WBUSY:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_banked_ram.sv
// Self-checking bench for banked_ram: table-driven vectors, hand-written corner sequences,
// and randomized traffic checked against a flat word-array reference model.
module tb_banked_ram;

    localparam int WORD_W = 10;
    localparam int LANES  = 2;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 21;
    localparam int BW     = LANES * WORD_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [LANES-1:0]  we;
    logic [ADDR_W-1:0] addr;
    logic [BW-1:0]     wdata;
    logic [BW-1:0]     rdata;
    logic              rvalid;
    logic              err;

    int n_checks = 0;
    int n_err    = 0;

    logic [WORD_W-1:0] model [DEPTH*LANES];
    logic [BW-1:0]     last_rd;

    banked_ram #(
        .WORD_W(WORD_W),
        .LANES (LANES),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string             name;
        logic [LANES-1:0]  we;
        int                addr;
        logic [BW-1:0]     wdata;
        logic              chk_rd;
        logic [BW-1:0]     exp_rdata;
        logic              exp_rvalid;
        logic              exp_err;
        logic              exp_ready;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pat(input int b);
        logic [WORD_W-1:0] hi, lo;
        hi = WORD_W'((b * 37 + 5) % 1024);
        lo = WORD_W'((b * 91 + 3) % 1024);
        return {hi, lo};
    endfunction

    function automatic logic [BW-1:0] model_read(input int a);
        logic [BW-1:0] r;
        r = '0;
        if (a < DEPTH) begin
            for (int l = 0; l < LANES; l++) r[l*WORD_W +: WORD_W] = model[a*LANES + l];
        end
        return r;
    endfunction

    task automatic model_apply(input logic [LANES-1:0] w, input int a, input logic [BW-1:0] d);
        if (a < DEPTH) begin
            for (int l = 0; l < LANES; l++) begin
                if (w[l]) model[a*LANES + l] = d[l*WORD_W +: WORD_W];
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_timeout", {63'd0, req_ready}, 64'd1);
    endtask

    // Present one request, hold it until accepted, then scramble the idle inputs.
    task automatic issue(input logic [LANES-1:0] w, input int a, input logic [BW-1:0] d);
        wait_ready();
        req_valid = 1'b1;
        we        = w;
        addr      = ADDR_W'(a);
        wdata     = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        we        = LANES'($urandom);
        wdata     = BW'($urandom);
    endtask

    vec_t tbl [8];

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        we        = '0;
        addr      = '0;
        wdata     = '0;

        // Reset: two cycles
        @(posedge clk); #1;
        chk("rst_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("rst_ready2", {63'd0, req_ready}, 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        last_rd = '0;

        for (int b = 0; b < DEPTH; b++) begin
            issue('1, b, pat(b));
            model_apply('1, b, pat(b));
        end

        tbl[0] = '{"w11_a3",     2'b11, 3,  20'h0C805, 1'b0, 20'h0,     1'b0, 1'b0, 1'b0};
        tbl[1] = '{"r_a3",       2'b00, 3,  20'h0,     1'b1, 20'h0C805, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{"w01_a3",     2'b01, 3,  20'h003FF, 1'b0, 20'h0,     1'b0, 1'b0, 1'b0};
        tbl[3] = '{"w10_a3",     2'b10, 3,  20'h15400, 1'b0, 20'h0,     1'b0, 1'b0, 1'b0};
        tbl[4] = '{"r_a3_mask",  2'b00, 3,  20'h0,     1'b1, 20'h157FF, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{"w11_a21",    2'b11, 21, 20'hFFFFF, 1'b1, 20'h157FF, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{"r_a21",      2'b00, 21, 20'h0,     1'b1, 20'h0,     1'b0, 1'b1, 1'b1};
        tbl[7] = '{"r_a20",      2'b00, 20, 20'h0,     1'b1, pat(20),   1'b1, 1'b0, 1'b1};

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            chk({tbl[i].name, "_rvalid"}, {63'd0, rvalid}, {63'd0, tbl[i].exp_rvalid});
            chk({tbl[i].name, "_err"}, {63'd0, err}, {63'd0, tbl[i].exp_err});
            chk({tbl[i].name, "_ready"}, {63'd0, req_ready}, {63'd0, tbl[i].exp_ready});
            if (tbl[i].chk_rd) chk({tbl[i].name, "_rdata"}, 64'(rdata), 64'(tbl[i].exp_rdata));
            model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].exp_ready) begin
                @(posedge clk); #1;
                chk({tbl[i].name, "_busy_end"}, {63'd0, req_ready}, 64'd1);
                chk({tbl[i].name, "_no_rvalid"}, {63'd0, rvalid}, 64'd0);
            end
        end
        last_rd = model_read(20);

        // Back-to-back reads with req_valid held
        wait_ready();
        req_valid = 1'b1;
        we        = '0;
        for (int a = 0; a < 3; a++) begin
            addr = ADDR_W'(a);
            @(posedge clk); #1;
            chk("b2b_rvalid", {63'd0, rvalid}, 64'd1);
            chk("b2b_rdata", 64'(rdata), 64'(model_read(a)));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_rvalid_drop", {63'd0, rvalid}, 64'd0);
        chk("b2b_rdata_hold", 64'(rdata), 64'(model_read(2)));

        // Read held through WBUSY returns freshly written data
        req_valid = 1'b1;
        we        = 2'b11;
        addr      = 9'd7;
        wdata     = 20'hABCDE;
        @(posedge clk); #1;
        model_apply(2'b11, 7, 20'hABCDE);
        chk("hold_wbusy_ready", {63'd0, req_ready}, 64'd0);
        we    = '0;
        wdata = 20'h13579;
        @(posedge clk); #1;
        chk("hold_not_accepted", {63'd0, rvalid}, 64'd0);
        chk("hold_ready_back", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold_rvalid", {63'd0, rvalid}, 64'd1);
        chk("hold_rdata", 64'(rdata), 64'(model_read(7)));

        // Reset coincident with a write request: nothing written
        rst       = 1'b1;
        req_valid = 1'b1;
        we        = 2'b11;
        addr      = 9'd5;
        wdata     = 20'h12345;
        #1;
        chk("rstw_ready_low", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rstw_ready", {63'd0, req_ready}, 64'd1);
        chk("rstw_rdata_zero", 64'(rdata), 64'd0);
        issue('0, 5, '0);
        chk("rstw_readback", 64'(rdata), 64'(model_read(5)));

        // Reset during WBUSY keeps the committed write
        issue(2'b11, 6, 20'h5A5A5);
        model_apply(2'b11, 6, 20'h5A5A5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstbusy_ready", {63'd0, req_ready}, 64'd1);
        issue('0, 6, '0);
        chk("rstbusy_readback", 64'(rdata), 64'(model_read(6)));
        last_rd = model_read(6);

        // Randomized traffic, including out-of-range beats
        for (int k = 0; k < 400; k++) begin
            logic [LANES-1:0] w;
            int               a;
            logic [BW-1:0]    d;
            logic             rd, inr;
            w   = ($urandom_range(0, 1) == 0) ? '0 : LANES'($urandom);
            a   = int'($urandom_range(0, DEPTH + 2));
            d   = BW'($urandom);
            rd  = (w == '0);
            inr = (a < DEPTH);
            issue(w, a, d);
            if (rd) last_rd = model_read(a);
            chk("rnd_rvalid", {63'd0, rvalid}, {63'd0, rd && inr});
            chk("rnd_err", {63'd0, err}, {63'd0, !inr});
            chk("rnd_ready", {63'd0, req_ready}, {63'd0, !(!rd && inr)});
            chk("rnd_rdata", 64'(rdata), 64'(last_rd));
            model_apply(w, a, d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
